pwm_duty_ramp: RTL and testbench

PWM_DUTY_RAMP -- requirements
Module: pwm_duty_ramp

---
 rtl/pwm_pkg.sv | 12 +
 rtl/pwm_period_counter.sv | 23 ++
 rtl/pwm_duty_ramp.sv | 106 ++++++++++
 tb/tb_pwm_duty_ramp.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared PWM definitions: ramp FSM state encoding and default duty width.
package pwm_pkg;

    localparam int PWM_N_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2
    } ramp_state_t;

endpackage

// File: rtl/pwm_period_counter.sv
// Free-running N-bit PWM period counter with an end-of-period tick.
module pwm_period_counter
    import pwm_pkg::*;
#(
    parameter int N = PWM_N_DEF
) (
    input  logic clk,
    input  logic reset,
    output logic period_tick
);

    logic [N-1:0] count;

    // Counter never stalls; it simply wraps from all-ones back to zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) count <= '0;
        else       count <= count + 1'b1;
    end

    // Last cycle of the period; low under reset because count is held at zero.
    assign period_tick = &count;

endmodule

// File: rtl/pwm_duty_ramp.sv
// Duty-cycle ramp generator: accepts a target/step pair and walks the
// registered duty word toward the target by one step per PWM period.
module pwm_duty_ramp
    import pwm_pkg::*;
#(
    parameter int N = PWM_N_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] target,
    input  logic [N-1:0] step,
    input  logic         target_valid,
    output logic         target_ready,
    output logic [N-1:0] duty,
    output logic         period_tick,
    output logic         busy,
    output logic         done
);

    ramp_state_t  state;
    logic [N-1:0] tgt_q;
    logic [N-1:0] stp_q;

    // All gap and sum arithmetic is one bit wider so nothing can wrap.
    logic [N:0] stp_ext;
    logic [N:0] up_gap;
    logic [N:0] dn_gap;
    logic [N:0] up_sum;
    logic [N:0] dn_sum;

    pwm_period_counter #(.N(N)) u_period (
        .clk         (clk),
        .reset       (reset),
        .period_tick (period_tick)
    );

    assign stp_ext = {1'b0, stp_q};
    assign up_gap  = {1'b0, tgt_q} - {1'b0, duty};
    assign dn_gap  = {1'b0, duty} - {1'b0, tgt_q};
    assign up_sum  = {1'b0, duty} + stp_ext;
    assign dn_sum  = {1'b0, duty} - stp_ext;

    // Only IDLE takes new work; offers while ramping are dropped.
    assign target_ready = (state == IDLE);

    // Ramp FSM: latch request in IDLE, then update duty once per period.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            duty  <= '0;
            tgt_q <= '0;
            stp_q <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // Duty is never touched here, even if this edge is a tick.
                    if (target_valid) begin
                        tgt_q <= target;
                        stp_q <= (step == '0) ? N'(1) : step;
                        if (target > duty) begin
                            state <= UP;
                            busy  <= 1'b1;
                        end else if (target < duty) begin
                            state <= DOWN;
                            busy  <= 1'b1;
                        end else begin
                            done  <= 1'b1;
                        end
                    end
                end
                UP: begin
                    if (period_tick) begin
                        if (up_gap <= stp_ext) begin
                            duty  <= tgt_q;
                            state <= IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            duty  <= up_sum[N-1:0];
                        end
                    end
                end
                DOWN: begin
                    if (period_tick) begin
                        if (dn_gap <= stp_ext) begin
                            duty  <= tgt_q;
                            state <= IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            duty  <= dn_sum[N-1:0];
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_duty_ramp.sv
// Directed bench for pwm_duty_ramp at N=8 (256-cycle period).
module tb_pwm_duty_ramp;

    localparam int N = 8;

    logic         clk;
    logic         reset;
    logic [N-1:0] target;
    logic [N-1:0] step;
    logic         target_valid;
    logic         target_ready;
    logic [N-1:0] duty;
    logic         period_tick;
    logic         busy;
    logic         done;

    int nvec;
    int nerr;

    pwm_duty_ramp #(.N(N)) dut (
        .clk          (clk),
        .reset        (reset),
        .target       (target),
        .step         (step),
        .target_valid (target_valid),
        .target_ready (target_ready),
        .duty         (duty),
        .period_tick  (period_tick),
        .busy         (busy),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock; sample/drive 1ns after the rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Offer a request for exactly one edge.
    task automatic send(input logic [N-1:0] t, input logic [N-1:0] s);
        chk("ready_before_send", target_ready, 1);
        target       = t;
        step         = s;
        target_valid = 1'b1;
        cyc();
        target_valid = 1'b0;
    endtask

    // Run until the cycle where the counter sits at its last value.
    task automatic wait_tick_hi();
        int n;
        n = 0;
        while (!period_tick && n < 300) begin
            cyc();
            n++;
        end
        chk("tick_seen", period_tick, 1);
    endtask

    // Cross one tick edge and check the resulting duty/done/busy.
    task automatic ramp_tick(input string tag, input int exp_duty, input bit exp_done);
        wait_tick_hi();
        cyc();
        chk({tag, "_duty"}, duty, exp_duty);
        chk({tag, "_done"}, done, exp_done);
        chk({tag, "_busy"}, busy, !exp_done);
        if (exp_done) begin
            cyc();
            chk({tag, "_done_pulse"}, done, 0);
            chk({tag, "_duty_hold"}, duty, exp_duty);
        end
    endtask

    // From reset release (1ns after an edge, counter at 0), the counter reaches
    // 255 after 255 edges, i.e. in the 256th cycle counting the release cycle.
    task automatic count_to_tick(input string tag);
        int n;
        n = 0;
        while (!period_tick && n < 300) begin
            cyc();
            n++;
        end
        chk({tag, "_tick_edges"}, n, 255);
    endtask

    initial begin
        int n;
        nvec         = 0;
        nerr         = 0;
        reset        = 1'b1;
        target       = '0;
        step         = '0;
        target_valid = 1'b0;

        // Reset state
        cyc();
        cyc();
        chk("rst_duty", duty, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ready", target_ready, 1);
        chk("rst_tick", period_tick, 0);
        reset = 1'b0;
        count_to_tick("rst");

        // Ramp up 0 -> 64 by 16 (transfer lands on a tick edge: duty holds)
        send(8'd64, 8'd16);
        chk("up_accept_duty", duty, 0);
        chk("up_accept_busy", busy, 1);
        chk("up_accept_ready", target_ready, 0);
        ramp_tick("up1", 16, 0);
        ramp_tick("up2", 32, 0);
        ramp_tick("up3", 48, 0);
        ramp_tick("up4", 64, 1);

        // Ramp down non-multiple 64 -> 10 by 20
        send(8'd10, 8'd20);
        chk("dn_busy", busy, 1);
        ramp_tick("dn1", 44, 0);
        ramp_tick("dn2", 24, 0);
        ramp_tick("dn3", 10, 1);

        // Reach 250 in one step (gap exactly equals step)
        send(8'd250, 8'd240);
        ramp_tick("to250", 250, 1);

        // Saturation: 250 -> 255 with step 16, then 255 -> 0 with step 255
        send(8'd255, 8'd16);
        ramp_tick("sat_hi", 255, 1);
        send(8'd0, 8'd255);
        ramp_tick("sat_lo", 0, 1);

        // Step of zero acts as one
        send(8'd2, 8'd0);
        ramp_tick("step0_a", 1, 0);
        ramp_tick("step0_b", 2, 1);

        // Equal target: done next cycle, no busy, duty unchanged
        send(8'd2, 8'd5);
        chk("eq_done", done, 1);
        chk("eq_busy", busy, 0);
        chk("eq_duty", duty, 2);
        cyc();
        chk("eq_done_pulse", done, 0);
        chk("eq_duty_hold", duty, 2);

        // Mid-ramp offer is ignored
        send(8'd20, 8'd4);
        ramp_tick("ign1", 6, 0);
        chk("ign_ready", target_ready, 0);
        target       = 8'd0;
        step         = 8'd1;
        target_valid = 1'b1;
        cyc();
        target_valid = 1'b0;
        chk("ign_busy", busy, 1);
        ramp_tick("ign2", 10, 0);
        ramp_tick("ign3", 14, 0);
        ramp_tick("ign4", 18, 0);
        ramp_tick("ign5", 20, 1);

        // Transfer on a tick edge: first step one full period later
        wait_tick_hi();
        send(8'd30, 8'd5);
        chk("ontick_duty", duty, 20);
        chk("ontick_busy", busy, 1);
        n = 0;
        while (duty == 8'd20 && n < 300) begin
            cyc();
            n++;
        end
        chk("ontick_latency", n, 256);
        chk("ontick_duty1", duty, 25);
        ramp_tick("ontick2", 30, 1);

        // Reset mid-ramp
        send(8'd200, 8'd8);
        ramp_tick("mr1", 38, 0);
        ramp_tick("mr2", 46, 0);
        ramp_tick("mr3", 54, 0);
        cyc();
        reset = 1'b1;
        #1;
        chk("mr_duty_async", duty, 0);
        chk("mr_busy", busy, 0);
        chk("mr_ready", target_ready, 1);
        chk("mr_done", done, 0);
        cyc();
        cyc();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("mr_no_done", done, 0);
            chk("mr_duty_idle", duty, 0);
        end
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        count_to_tick("mr");
        cyc();
        chk("mr_final_duty", duty, 0);
        chk("mr_final_busy", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
